// File: rtl/spi_rom_fetch.sv
// Fetches one 16-bit word from a 25-series SPI EEPROM (mode 0, READ 0x03),
// with a single-entry last-word cache in front of it.
module spi_rom_fetch #(
  parameter int          CLK_DIV   = 4,
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic [14:0] word_address,
  input  logic        start,
  input  logic        invalidate,
  output logic [15:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] DIV_M1  = 8'(CLK_DIV - 1);
  localparam logic [7:0] READ_OP = 8'h03;

  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  bitn;
  logic        phase;
  logic [31:0] sr;
  logic [15:0] rx;
  logic [14:0] addr_q;
  logic        c_valid;
  logic [14:0] c_addr;
  logic [15:0] c_word;

  logic [23:0] byte_addr;
  logic        cache_hit;
  logic        cnt_end;

  assign byte_addr = BASE_ADDR + {8'h00, word_address, 1'b0};
  assign cache_hit = c_valid && (c_addr == word_address) && !invalidate;
  assign cnt_end   = (cnt == DIV_M1);

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bitn     <= '0;
      phase    <= 1'b0;
      sr       <= '0;
      rx       <= '0;
      addr_q   <= '0;
      c_valid  <= 1'b0;
      c_addr   <= '0;
      c_word   <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      ready <= 1'b0;
      // a completing fill below overrides this clear
      if (invalidate) c_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            addr_q <= word_address;
            cnt    <= '0;
            if (cache_hit) begin
              state    <= DONE;
              ready    <= 1'b1;
              data_out <= c_word;
            end else begin
              sr       <= {READ_OP, byte_addr};
              spi_cs   <= 1'b0;
              spi_mosi <= READ_OP[7];
              bitn     <= '0;
              phase    <= 1'b0;
              state    <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt_end) begin
            cnt      <= '0;
            spi_mosi <= sr[31];
            state    <= SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (!cnt_end) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= '0;
            if (!phase) begin
              phase   <= 1'b1;
              spi_clk <= 1'b1;
              rx      <= {rx[14:0], spi_miso};
              sr      <= {sr[30:0], 1'b0};
            end else begin
              phase   <= 1'b0;
              spi_clk <= 1'b0;
              if (bitn == 6'd47) begin
                state <= HOLD;
              end else begin
                bitn     <= bitn + 6'd1;
                spi_mosi <= sr[31];
              end
            end
          end
        end
        HOLD: begin
          if (cnt_end) begin
            state    <= DONE;
            spi_cs   <= 1'b1;
            ready    <= 1'b1;
            data_out <= rx;
            c_word   <= rx;
            c_addr   <= addr_q;
            c_valid  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
